// File: rtl/aes_inv_sbox_word.sv
// -----------------------------------------------------------------------------
// aes_inv_sbox_word
//   Iterative InvSubBytes engine for the AES decryption datapath. Each byte of
//   a 32-bit word is passed through the inverse affine transform and then the
//   GF(2^8) multiplicative inverse. The inverse is computed in the composite
//   field GF((2^4)^2) built from GF(2^4) = GF(2)[y]/(y^4+y+1) and
//   GF(2^4)[z]/(z^2+z+lambda), lambda = 4'hE. NUM_LANES bytes are processed
//   per cycle, so a word takes ITER = 4/NUM_LANES cycles.
//
// Ports
//   clk_i    in   1   clock, rising edge
//   rst_ni   in   1   synchronous active-low reset
//   valid_i  in   1   word_i is valid
//   ready_o  out  1   block can accept a word (IDLE)
//   word_i   in   32  input word, byte k = word_i[8k+7:8k]
//   valid_o  out  1   word_o is valid (DONE)
//   ready_i  in   1   downstream accepts word_o
//   word_o   out  32  InvSubBytes(word_i), same byte positions
//   busy_o   out  1   state is not IDLE
// -----------------------------------------------------------------------------
module aes_inv_sbox_word #(
  parameter int NUM_LANES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] word_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] word_o,
  output logic        busy_o
);

  localparam int ITER = 4 / NUM_LANES;

  generate
    if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
      $error("aes_inv_sbox_word: NUM_LANES must be 1, 2 or 4");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // GF(2^4) primitives, field polynomial y^4 + y + 1
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      // multiply by y, folding y^4 back to y + 1
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0 as required
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  // ---------------------------------------------------------------------------
  // Isomorphism GF(2^8) (AES basis) <-> GF((2^4)^2); columns are powers of a
  // root beta = 8'h26 of x^8+x^4+x^3+x+1 in the composite field.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] map_iso(input logic [7:0] a);
    logic [7:0] q;
    q[0] = a[0] ^ a[4] ^ a[5] ^ a[6];
    q[1] = a[1] ^ a[2];
    q[2] = a[1] ^ a[7];
    q[3] = a[2] ^ a[4];
    q[4] = a[4] ^ a[5] ^ a[6];
    q[5] = a[1] ^ a[4] ^ a[6] ^ a[7];
    q[6] = a[2] ^ a[3] ^ a[5] ^ a[7];
    q[7] = a[5] ^ a[7];
    return q;
  endfunction

  function automatic logic [7:0] map_iso_inv(input logic [7:0] q);
    logic [7:0] r;
    r[0] = q[0] ^ q[4];
    r[1] = q[4] ^ q[5] ^ q[7];
    r[2] = q[1] ^ q[4] ^ q[5] ^ q[7];
    r[3] = q[1] ^ q[4] ^ q[5] ^ q[6];
    r[4] = q[1] ^ q[3] ^ q[4] ^ q[5] ^ q[7];
    r[5] = q[2] ^ q[4] ^ q[5];
    r[6] = q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[7];
    r[7] = q[2] ^ q[4] ^ q[5] ^ q[7];
    return r;
  endfunction

  // (h z + l)^-1 = (h d^-1) z + (h + l) d^-1, d = h^2*lambda + h*l + l^2
  function automatic logic [7:0] gf8_inv(input logic [7:0] a);
    logic [7:0] q;
    logic [3:0] h, l, d, di;
    q  = map_iso(a);
    h  = q[7:4];
    l  = q[3:0];
    d  = gf4_mul(gf4_sq(h), 4'hE) ^ gf4_mul(h, l) ^ gf4_sq(l);
    di = gf4_inv(d);
    return map_iso_inv({gf4_mul(h, di), gf4_mul(h ^ l, di)});
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf8_inv(inv_affine(a));
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [31:0] r_word_in;
  logic [31:0] r_word_o;
  logic        w_last;
  logic [7:0]  w_lane_in  [NUM_LANES];
  logic [7:0]  w_lane_out [NUM_LANES];

  assign w_last = (r_cnt == 2'(ITER - 1));

  // Byte k belongs to group k/NUM_LANES and is handled by lane k%NUM_LANES.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) w_lane_in[l] = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_cnt == 2'(k / NUM_LANES)) w_lane_in[k % NUM_LANES] = r_word_in[8*k +: 8];
    end
  end

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_lane_out[g] = inv_sbox(w_lane_in[g]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: next state and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      DONE: begin
        if (ready_i) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: capture on accept, write back the processed group in BUSY.
  // Unprocessed bytes keep their previous value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_word_in <= '0;
      r_word_o  <= '0;
    end else begin
      if (r_state == IDLE && valid_i) r_word_in <= word_i;
      if (r_state == BUSY) begin
        for (int k = 0; k < 4; k++) begin
          if (r_cnt == 2'(k / NUM_LANES)) r_word_o[8*k +: 8] <= w_lane_out[k % NUM_LANES];
        end
      end
    end
  end

  assign ready_o = (r_state == IDLE);
  assign valid_o = (r_state == DONE);
  assign busy_o  = (r_state != IDLE);
  assign word_o  = r_word_o;

endmodule

// File: tb/tb_aes_inv_sbox_word.sv
module tb_aes_inv_sbox_word;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_in  [3];
  logic [31:0] w_in  [3];
  logic        r_in  [3];
  logic        v_out [3];
  logic        r_out [3];
  logic [31:0] w_out [3];
  logic        b_out [3];

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0] ref_tab [256];

  always #5 clk = ~clk;

  aes_inv_sbox_word #(.NUM_LANES(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_in[0]), .ready_o(r_out[0]), .word_i(w_in[0]),
    .valid_o(v_out[0]), .ready_i(r_in[0]), .word_o(w_out[0]), .busy_o(b_out[0]));

  aes_inv_sbox_word #(.NUM_LANES(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_in[1]), .ready_o(r_out[1]), .word_i(w_in[1]),
    .valid_o(v_out[1]), .ready_i(r_in[1]), .word_o(w_out[1]), .busy_o(b_out[1]));

  aes_inv_sbox_word #(.NUM_LANES(4)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_in[2]), .ready_o(r_out[2]), .word_i(w_in[2]),
    .valid_o(v_out[2]), .ready_i(r_in[2]), .word_o(w_out[2]), .busy_o(b_out[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_ref();
    logic [7:0] a, b, c;
    for (int v = 0; v < 256; v++) begin
      a = 8'(v);
      b = ((a << 1) | (a >> 7)) ^ ((a << 3) | (a >> 5)) ^ ((a << 6) | (a >> 2)) ^ 8'h05;
      c = 8'h00;
      if (b != 0) begin
        for (int t = 1; t < 256; t++) if (gmul(b, 8'(t)) == 8'h01) c = 8'(t);
      end
      ref_tab[v] = c;
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    return {ref_tab[w[31:24]], ref_tab[w[23:16]], ref_tab[w[15:8]], ref_tab[w[7:0]]};
  endfunction

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 2 : 1;
  endfunction

  // Offer one word and wait for valid_o; called at a negedge, returns at the
  // negedge where valid_o is first seen high.
  task automatic send_recv(input int idx, input logic [31:0] w,
                           output logic [31:0] res, output int lat, output bit ok);
    int guard;
    ok = 0; res = '0; lat = 0; guard = 0;
    while (!r_out[idx] && guard < 50) begin @(negedge clk); guard++; end
    if (!r_out[idx]) begin
      n_checks++; n_errs++;
      $display("FAIL accept_timeout[%0d]: ready_o=%b required 1", idx, r_out[idx]);
      return;
    end
    v_in[idx] = 1'b1; w_in[idx] = w;
    @(negedge clk);
    v_in[idx] = 1'b0;
    while (!v_out[idx] && lat < 20) begin @(negedge clk); lat++; end
    if (!v_out[idx]) begin
      n_checks++; n_errs++;
      $display("FAIL result_timeout[%0d]: valid_o=%b required 1", idx, v_out[idx]);
      return;
    end
    res = w_out[idx];
    ok  = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin v_in[i] = 0; w_in[i] = '0; r_in[i] = 0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (v_out[i] !== 1'b0) begin n_errs++; $display("FAIL reset_valid[%0d]: got %b want 0", i, v_out[i]); end
      n_checks++; if (w_out[i] !== 32'h0) begin n_errs++; $display("FAIL reset_word[%0d]: got %h want 0", i, w_out[i]); end
      n_checks++; if (b_out[i] !== 1'b0) begin n_errs++; $display("FAIL reset_busy[%0d]: got %b want 0", i, b_out[i]); end
      n_checks++; if (r_out[i] !== 1'b1) begin n_errs++; $display("FAIL reset_ready[%0d]: got %b want 1", i, r_out[i]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vector();
    logic [31:0] res; int lat; bit ok;
    r_in[0] = 1'b1;
    send_recv(0, 32'h637C16ED, res, lat, ok);
    if (ok) begin
      n_checks++; if (res !== 32'h0001FF53) begin n_errs++; $display("FAIL known_word: got %h want 0001ff53", res); end
      n_checks++; if (lat !== 4) begin n_errs++; $display("FAIL known_latency: got %0d want 4", lat); end
      @(negedge clk);
      n_checks++;
      if (r_out[0] !== 1'b1 || v_out[0] !== 1'b0 || b_out[0] !== 1'b0) begin
        n_errs++; $display("FAIL known_back_idle: ready=%b valid=%b busy=%b want 1 0 0", r_out[0], v_out[0], b_out[0]);
      end
    end
  endtask

  task automatic test_corner_words();
    logic [31:0] res; int lat; bit ok;
    r_in[0] = 1'b1;
    send_recv(0, 32'h00000000, res, lat, ok);
    if (ok) begin
      n_checks++; if (res !== 32'h52525252) begin n_errs++; $display("FAIL zero_word: got %h want 52525252", res); end
    end
    send_recv(0, 32'h01010101, res, lat, ok);
    if (ok) begin
      n_checks++; if (res !== 32'h09090909) begin n_errs++; $display("FAIL ones_word: got %h want 09090909", res); end
    end
  endtask

  task automatic exh_lane(input int idx);
    logic [31:0] w, res; int lat; bit ok;
    r_in[idx] = 1'b1;
    for (int v = 0; v < 256; v++) begin
      w = {8'(v + 3), 8'(v + 2), 8'(v + 1), 8'(v)};
      send_recv(idx, w, res, lat, ok);
      if (ok) begin
        n_checks++; if (res !== ref_word(w)) begin n_errs++; $display("FAIL exh_word[%0d] in=%h: got %h want %h", idx, w, res, ref_word(w)); end
        n_checks++; if (lat !== lat_of(idx)) begin n_errs++; $display("FAIL exh_latency[%0d]: got %0d want %0d", idx, lat, lat_of(idx)); end
      end
    end
  endtask

  task automatic test_exhaustive();
    fork
      exh_lane(0);
      exh_lane(1);
      exh_lane(2);
    join
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] res, w, res2; int lat; bit ok; int xfers;
    w = 32'hA5_3C_E1_07;
    r_in[0] = 1'b0;
    send_recv(0, w, res, lat, ok);
    if (!ok) return;
    n_checks++; if (res !== ref_word(w)) begin n_errs++; $display("FAIL bp_word: got %h want %h", res, ref_word(w)); end
    for (int c = 0; c < 10; c++) begin
      v_in[0] = c[0]; w_in[0] = $urandom;
      @(negedge clk);
      n_checks++;
      if (v_out[0] !== 1'b1 || w_out[0] !== res || r_out[0] !== 1'b0) begin
        n_errs++; $display("FAIL bp_hold c=%0d: valid=%b word=%h ready=%b want 1 %h 0", c, v_out[0], w_out[0], r_out[0], res);
      end
    end
    v_in[0] = 1'b0;
    r_in[0] = 1'b1;
    xfers = 0;
    for (int c = 0; c < 6; c++) begin
      if (v_out[0] && r_in[0]) xfers++;
      @(negedge clk);
    end
    n_checks++; if (xfers !== 1) begin n_errs++; $display("FAIL bp_transfers: got %0d want 1", xfers); end
    n_checks++; if (r_out[0] !== 1'b1 || v_out[0] !== 1'b0) begin n_errs++; $display("FAIL bp_idle: ready=%b valid=%b want 1 0", r_out[0], v_out[0]); end
    send_recv(0, 32'h1234_5678, res2, lat, ok);
    if (ok) begin
      n_checks++; if (res2 !== ref_word(32'h1234_5678)) begin n_errs++; $display("FAIL bp_next: got %h want %h", res2, ref_word(32'h1234_5678)); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res; int lat; bit ok;
    r_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v_in[0] = 1'b1; w_in[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    v_in[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (b_out[0] !== 1'b1) begin n_errs++; $display("FAIL mid_busy: got %b want 1", b_out[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (v_out[0] !== 1'b0) begin n_errs++; $display("FAIL rst_mid_valid: got %b want 0", v_out[0]); end
    n_checks++; if (w_out[0] !== 32'h0) begin n_errs++; $display("FAIL rst_mid_word: got %h want 0", w_out[0]); end
    n_checks++; if (b_out[0] !== 1'b0) begin n_errs++; $display("FAIL rst_mid_busy: got %b want 0", b_out[0]); end
    n_checks++; if (r_out[0] !== 1'b1) begin n_errs++; $display("FAIL rst_mid_ready: got %b want 1", r_out[0]); end
    send_recv(0, 32'h0F1E_2D3C, res, lat, ok);
    if (ok) begin
      n_checks++; if (res !== ref_word(32'h0F1E_2D3C)) begin n_errs++; $display("FAIL rst_after_word: got %h want %h", res, ref_word(32'h0F1E_2D3C)); end
      n_checks++; if (lat !== 4) begin n_errs++; $display("FAIL rst_after_latency: got %0d want 4", lat); end
    end
    @(negedge clk);
  endtask

  task automatic stream_lane(input int idx, input int n);
    logic [31:0] exp_q[$];
    logic [31:0] cur_w, exp_w;
    bit offering, will_acc;
    int sent, recv, cyc;
    logic rdy;
    offering = 0; will_acc = 0; sent = 0; recv = 0; cyc = 0; cur_w = '0;
    v_in[idx] = 1'b0;
    while (recv < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      rdy = 1'($urandom_range(0, 1));
      r_in[idx] = rdy;
      if (v_out[idx] && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errs++; $display("FAIL stream_extra[%0d]: got %h with nothing outstanding", idx, w_out[idx]);
        end else begin
          exp_w = exp_q.pop_front();
          if (w_out[idx] !== exp_w) begin n_errs++; $display("FAIL stream_word[%0d] #%0d: got %h want %h", idx, recv, w_out[idx], exp_w); end
        end
        recv++;
      end
      if (will_acc) offering = 0;
      if (!offering && sent < n && $urandom_range(0, 3) != 0) begin
        cur_w = $urandom;
        offering = 1;
      end
      v_in[idx] = offering;
      w_in[idx] = offering ? cur_w : $urandom;
      will_acc = offering && r_out[idx];
      if (will_acc) begin exp_q.push_back(ref_word(cur_w)); sent++; end
    end
    n_checks++;
    if (recv !== n || exp_q.size() != 0) begin
      n_errs++; $display("FAIL stream_count[%0d]: got %0d outstanding %0d want %0d and 0", idx, recv, exp_q.size(), n);
    end
    v_in[idx] = 1'b0;
    r_in[idx] = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (v_out[idx] !== 1'b0) begin n_errs++; $display("FAIL stream_tail[%0d]: valid=%b want 0", idx, v_out[idx]); end
  endtask

  task automatic test_back_to_back();
    fork
      stream_lane(0, 1000);
      stream_lane(1, 1000);
      stream_lane(2, 1000);
    join
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_ref();
    test_reset();
    test_known_vector();
    test_corner_words();
    test_exhaustive();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
